// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: retires BITS_PER_CYCLE multiplier bits per RUN cycle,
// unsigned or two's-complement, with fixed latency of WIDTH/BITS_PER_CYCLE cycles.
module seq_shift_add_mult #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: start is taken on any rising edge where ready=1; done pulses
  // for exactly the one cycle in which product first shows the new result.
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, acc_q, product_q, sum, pp;
  logic [WIDTH-1:0]     b_q;
  logic                 mode_q;
  logic [CW-1:0]        cnt_q;
  logic                 accept, last;

  assign accept  = start && (state_q != RUN);
  assign last    = (cnt_q == LAST);
  assign product = product_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a_q and b_q shift every cycle, so bit k of b_q always pairs with a_q << k.
  // The original multiplier MSB lands at k = BITS_PER_CYCLE-1 of the final
  // chunk; in signed mode that partial product carries weight -2^(WIDTH-1).
  always_comb begin
    sum = acc_q;
    pp  = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      pp = b_q[k] ? (a_q << k) : '0;
      if (mode_q && last && (k == BITS_PER_CYCLE - 1)) sum = sum - pp;
      else                                             sum = sum + pp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      a_q    <= signed_mode ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                            : {{WIDTH{1'b0}}, multiplicand};
      b_q    <= multiplier;
      mode_q <= signed_mode;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      acc_q <= sum;
      a_q   <= a_q << BITS_PER_CYCLE;
      b_q   <= b_q >> BITS_PER_CYCLE;
      cnt_q <= cnt_q + CW'(1);
      if (last) product_q <= sum;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult: one instance at BITS_PER_CYCLE=1, one at 4.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_mode;
  logic [15:0] multiplicand, multiplier;
  logic        ready, busy, done;
  logic [31:0] product;

  logic        start4, signed_mode4;
  logic [15:0] multiplicand4, multiplier4;
  logic        ready4, busy4, done4;
  logic [31:0] product4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  seq_shift_add_mult #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(signed_mode4),
    .multiplicand(multiplicand4), .multiplier(multiplier4),
    .ready(ready4), .busy(busy4), .done(done4), .product(product4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one multiply on the 1-bit/cycle instance, wait for done, check latency and product.
  task automatic op1(input string tag, input logic m, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp);
    int lat;
    start = 1'b1; signed_mode = m; multiplicand = a; multiplier = b;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'd16);
    chk({tag, "_product"}, product, exp);
    tick();
  endtask

  task automatic op4(input string tag, input logic m, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp);
    int lat;
    start4 = 1'b1; signed_mode4 = m; multiplicand4 = a; multiplier4 = b;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 40) begin tick(); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_product"}, product4, exp);
    tick();
  endtask

  initial begin
    int lat, busy_cnt, done_cnt;
    logic hold_ok;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    start4 = 1'b0; signed_mode4 = 1'b0; multiplicand4 = '0; multiplier4 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_ready",   32'(ready),   32'd1);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_product", product,      32'd0);
    chk("reset_product4", product4,    32'd0);

    // Unsigned max*max with busy-width and early-done tracking
    start = 1'b1; signed_mode = 1'b0; multiplicand = 16'hFFFF; multiplier = 16'hFFFF;
    tick();
    start = 1'b0;
    chk("run_ready", 32'(ready), 32'd0);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      tick();
    end
    chk("umax_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("umax_early_done",  32'(done_cnt), 32'd0);
    chk("umax_done",        32'(done),     32'd1);
    chk("umax_product",     product,       32'hFFFE0001);
    chk("done_ready",       32'(ready),    32'd1);
    chk("done_busy",        32'(busy),     32'd0);
    tick();
    chk("done_one_cycle",   32'(done),     32'd0);
    chk("idle_product_hold", product,      32'hFFFE0001);

    op1("s_m1xm1",   1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
    op1("s_minx2",   1'b1, 16'h8000, 16'h0002, 32'hFFFF0000);
    op1("s_minxmin", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    op1("s_m3x5",    1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1);

    // Back-to-back: second start issued in the DONE cycle
    start = 1'b1; signed_mode = 1'b0; multiplicand = 16'd3; multiplier = 16'd5;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("b2b_op1_product", product, 32'h0000000F);
    start = 1'b1; multiplicand = 16'd7; multiplier = 16'd9;
    tick();
    start = 1'b0;
    chk("b2b_no_idle_busy", 32'(busy), 32'd1);
    lat = 0; hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (product !== 32'h0000000F) hold_ok = 1'b0;
      tick(); lat++;
    end
    chk("b2b_product_hold", 32'(hold_ok), 32'd1);
    chk("b2b_latency",      32'(lat),     32'd16);
    chk("b2b_op2_product",  product,      32'h0000003F);
    tick();

    // Mid-RUN start pulse and operand change are ignored
    start = 1'b1; signed_mode = 1'b0; multiplicand = 16'h0012; multiplier = 16'h0034;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; signed_mode = 1'b1; multiplicand = 16'hABCD; multiplier = 16'h8765;
    tick();
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("ignore_latency", 32'(lat), 32'd16);
    chk("ignore_product", product,  32'h000003A8);
    tick();
    chk("ignore_idle_after", 32'(busy), 32'd0);

    // Reset at RUN cycle 8 aborts the operation
    start = 1'b1; signed_mode = 1'b0; multiplicand = 16'h00FF; multiplier = 16'h00FF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",    32'(busy),  32'd0);
    chk("abort_ready",   32'(ready), 32'd1);
    chk("abort_product", product,    32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    op1("post_abort_2x3", 1'b0, 16'd2, 16'd3, 32'h00000006);

    // Four bits per cycle
    op4("b4_u1234x5678", 1'b0, 16'h1234, 16'h5678, 32'h06260060);
    op4("b4_umax",       1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    op4("b4_sm1x3",      1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD);
    op4("b4_sminxmin",   1'b1, 16'h8000, 16'h8000, 32'h40000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
